// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, and the EX/MEM pipeline register.
// Latency: 1 cycle from ID/EX inputs to EX/MEM outputs; forwarding is combinational.
// Backpressure: Stall holds EX/MEM; Flush loads a bubble; Reset overrides both.
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [DATA_W-1:0] ID_EX_ReadData1,
  input  logic [DATA_W-1:0] ID_EX_ReadData2,
  input  logic [DATA_W-1:0] ID_EX_Imm,
  input  logic [4:0]        ID_EX_Shamt,
  input  logic [4:0]        ID_EX_Rt,
  input  logic [4:0]        ID_EX_Rd,
  input  logic              ID_EX_RegDst,
  input  logic              ID_EX_ALUSrc,
  input  logic [3:0]        ID_EX_ALUOp,
  input  logic              ID_EX_RegWrite,
  input  logic              ID_EX_MemWrite,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_MemToReg,
  input  logic [1:0]        forwardA,
  input  logic [1:0]        forwardB,
  input  logic [DATA_W-1:0] MEM_WB_WriteData,
  output logic [DATA_W-1:0] EX_MEM_ALUResult,
  output logic [DATA_W-1:0] EX_MEM_WriteData,
  output logic [4:0]        EX_MEM_Rd,
  output logic              EX_MEM_Zero,
  output logic              EX_MEM_Overflow,
  output logic              EX_MEM_RegWrite,
  output logic              EX_MEM_MemWrite,
  output logic              EX_MEM_MemRead,
  output logic              EX_MEM_MemToReg
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  // Everything the EX/MEM register carries, kept together so stall/flush/reset
  // treat every field identically.
  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [4:0]        rd;
    logic              zero;
    logic              overflow;
    logic              reg_write;
    logic              mem_write;
    logic              mem_read;
    logic              mem_to_reg;
  } exmem_t;

  exmem_t            exmem_q;
  exmem_t            exmem_d;
  exmem_t            exmem_calc;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] add_res;
  logic [DATA_W-1:0] sub_res;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  // Operand forwarding: 10 = one-ahead (our own EX/MEM result), 01 = two-ahead
  // (MEM/WB write-back); 11 is unused by the forwarding unit and falls back to
  // the register file.
  always_comb begin
    op_a = ID_EX_ReadData1;
    case (forwardA)
      2'b10:   op_a = exmem_q.alu_result;
      2'b01:   op_a = MEM_WB_WriteData;
      default: op_a = ID_EX_ReadData1;
    endcase
    fwd_b = ID_EX_ReadData2;
    case (forwardB)
      2'b10:   fwd_b = exmem_q.alu_result;
      2'b01:   fwd_b = MEM_WB_WriteData;
      default: fwd_b = ID_EX_ReadData2;
    endcase
    op_b = ID_EX_ALUSrc ? ID_EX_Imm : fwd_b;
  end

  // ALU: result plus signed overflow, which is only meaningful for ADD/SUB.
  always_comb begin
    add_res = op_a + op_b;
    sub_res = op_a - op_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ID_EX_ALUOp)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                  (add_res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                  (sub_res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  alu_res = op_b << ID_EX_Shamt;
      OP_SRL:  alu_res = op_b >> ID_EX_Shamt;
      OP_SRA:  alu_res = DATA_W'($signed(op_b) >>> ID_EX_Shamt);
      default: alu_res = '0;
    endcase
  end

  // Assemble the values a normal load would capture; store data is always the
  // forwarded B operand, independent of the immediate select.
  always_comb begin
    exmem_calc            = '0;
    exmem_calc.alu_result = alu_res;
    exmem_calc.write_data = fwd_b;
    exmem_calc.rd         = ID_EX_RegDst ? ID_EX_Rd : ID_EX_Rt;
    exmem_calc.zero       = (alu_res == '0);
    exmem_calc.overflow   = alu_ovf;
    exmem_calc.reg_write  = ID_EX_RegWrite;
    exmem_calc.mem_write  = ID_EX_MemWrite;
    exmem_calc.mem_read   = ID_EX_MemRead;
    exmem_calc.mem_to_reg = ID_EX_MemToReg;
  end

  // Next-state selection: a flush bubble beats a stall hold, which beats a load.
  always_comb begin
    exmem_d = exmem_calc;
    if (Flush) begin
      exmem_d = '0;
    end else if (Stall) begin
      exmem_d = exmem_q;
    end
  end

  // EX/MEM register with synchronous reset taking priority over everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign EX_MEM_ALUResult = exmem_q.alu_result;
  assign EX_MEM_WriteData = exmem_q.write_data;
  assign EX_MEM_Rd        = exmem_q.rd;
  assign EX_MEM_Zero      = exmem_q.zero;
  assign EX_MEM_Overflow  = exmem_q.overflow;
  assign EX_MEM_RegWrite  = exmem_q.reg_write;
  assign EX_MEM_MemWrite  = exmem_q.mem_write;
  assign EX_MEM_MemRead   = exmem_q.mem_read;
  assign EX_MEM_MemToReg  = exmem_q.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU corners, store path,
// stall/flush/reset priority and destination select.
module tb_ex_stage;

  localparam int DATA_W = 32;

  logic              Clk;
  logic              Reset;
  logic              Stall;
  logic              Flush;
  logic [DATA_W-1:0] ID_EX_ReadData1;
  logic [DATA_W-1:0] ID_EX_ReadData2;
  logic [DATA_W-1:0] ID_EX_Imm;
  logic [4:0]        ID_EX_Shamt;
  logic [4:0]        ID_EX_Rt;
  logic [4:0]        ID_EX_Rd;
  logic              ID_EX_RegDst;
  logic              ID_EX_ALUSrc;
  logic [3:0]        ID_EX_ALUOp;
  logic              ID_EX_RegWrite;
  logic              ID_EX_MemWrite;
  logic              ID_EX_MemRead;
  logic              ID_EX_MemToReg;
  logic [1:0]        forwardA;
  logic [1:0]        forwardB;
  logic [DATA_W-1:0] MEM_WB_WriteData;
  logic [DATA_W-1:0] EX_MEM_ALUResult;
  logic [DATA_W-1:0] EX_MEM_WriteData;
  logic [4:0]        EX_MEM_Rd;
  logic              EX_MEM_Zero;
  logic              EX_MEM_Overflow;
  logic              EX_MEM_RegWrite;
  logic              EX_MEM_MemWrite;
  logic              EX_MEM_MemRead;
  logic              EX_MEM_MemToReg;

  int checks = 0;
  int errors = 0;

  ex_stage #(.DATA_W(DATA_W)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Stall            (Stall),
    .Flush            (Flush),
    .ID_EX_ReadData1  (ID_EX_ReadData1),
    .ID_EX_ReadData2  (ID_EX_ReadData2),
    .ID_EX_Imm        (ID_EX_Imm),
    .ID_EX_Shamt      (ID_EX_Shamt),
    .ID_EX_Rt         (ID_EX_Rt),
    .ID_EX_Rd         (ID_EX_Rd),
    .ID_EX_RegDst     (ID_EX_RegDst),
    .ID_EX_ALUSrc     (ID_EX_ALUSrc),
    .ID_EX_ALUOp      (ID_EX_ALUOp),
    .ID_EX_RegWrite   (ID_EX_RegWrite),
    .ID_EX_MemWrite   (ID_EX_MemWrite),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_MemToReg   (ID_EX_MemToReg),
    .forwardA         (forwardA),
    .forwardB         (forwardB),
    .MEM_WB_WriteData (MEM_WB_WriteData),
    .EX_MEM_ALUResult (EX_MEM_ALUResult),
    .EX_MEM_WriteData (EX_MEM_WriteData),
    .EX_MEM_Rd        (EX_MEM_Rd),
    .EX_MEM_Zero      (EX_MEM_Zero),
    .EX_MEM_Overflow  (EX_MEM_Overflow),
    .EX_MEM_RegWrite  (EX_MEM_RegWrite),
    .EX_MEM_MemWrite  (EX_MEM_MemWrite),
    .EX_MEM_MemRead   (EX_MEM_MemRead),
    .EX_MEM_MemToReg  (EX_MEM_MemToReg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every registered output must be zero (reset or bubble).
  task automatic chk_all_zero(input string tag);
    chk({tag, ".alu"}, EX_MEM_ALUResult, 32'h0);
    chk({tag, ".wd"},  EX_MEM_WriteData, 32'h0);
    chk({tag, ".rd"},  {27'h0, EX_MEM_Rd}, 32'h0);
    chk({tag, ".zero"}, {31'h0, EX_MEM_Zero}, 32'h0);
    chk({tag, ".ovf"},  {31'h0, EX_MEM_Overflow}, 32'h0);
    chk({tag, ".ctl"},  {28'h0, EX_MEM_RegWrite, EX_MEM_MemWrite,
                         EX_MEM_MemRead, EX_MEM_MemToReg}, 32'h0);
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Plain register-register ALU op with no forwarding.
  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ID_EX_ALUOp     = op;
    ID_EX_ReadData1 = a;
    ID_EX_ReadData2 = b;
    ID_EX_ALUSrc    = 1'b0;
    forwardA        = 2'b00;
    forwardB        = 2'b00;
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b1; Flush = 1'b0;
    ID_EX_ReadData1 = $urandom; ID_EX_ReadData2 = $urandom;
    ID_EX_Imm = $urandom; ID_EX_Shamt = 5'd3;
    ID_EX_Rt = 5'd7; ID_EX_Rd = 5'd11; ID_EX_RegDst = 1'b1; ID_EX_ALUSrc = 1'b0;
    ID_EX_ALUOp = 4'b0010; ID_EX_RegWrite = 1'b1; ID_EX_MemWrite = 1'b1;
    ID_EX_MemRead = 1'b1; ID_EX_MemToReg = 1'b1;
    forwardA = 2'b00; forwardB = 2'b00; MEM_WB_WriteData = $urandom;

    // Reset with Stall asserted and random inputs.
    tick();
    chk_all_zero("reset");

    // First instruction after reset loads normally.
    Reset = 1'b0; Stall = 1'b0;
    ID_EX_MemWrite = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_MemToReg = 1'b0;
    ID_EX_RegDst = 1'b1; ID_EX_Rd = 5'd3;
    alu(4'b0010, 32'd5, 32'd7);
    tick();
    chk("add5_7.alu", EX_MEM_ALUResult, 32'd12);
    chk("add5_7.zero", {31'h0, EX_MEM_Zero}, 32'h0);
    chk("add5_7.rd", {27'h0, EX_MEM_Rd}, 32'd3);
    chk("add5_7.regwrite", {31'h0, EX_MEM_RegWrite}, 32'h1);

    // Forwarding A.
    ID_EX_Rd = 5'd8;
    alu(4'b0010, 32'd3, 32'd4);
    tick();
    chk("fwd.add3_4", EX_MEM_ALUResult, 32'd7);
    alu(4'b0110, 32'd99, 32'd7);
    forwardA = 2'b10;
    tick();
    chk("fwd.a10.alu", EX_MEM_ALUResult, 32'd0);
    chk("fwd.a10.zero", {31'h0, EX_MEM_Zero}, 32'h1);
    forwardA = 2'b01; MEM_WB_WriteData = 32'd20;
    tick();
    chk("fwd.a01", EX_MEM_ALUResult, 32'd13);
    chk("fwd.a01.zero", {31'h0, EX_MEM_Zero}, 32'h0);
    forwardA = 2'b11;
    tick();
    chk("fwd.a11", EX_MEM_ALUResult, 32'd92);

    // ALU corners.
    alu(4'b0010, 32'h7FFF_FFFF, 32'h1);
    tick();
    chk("add_ovf.alu", EX_MEM_ALUResult, 32'h8000_0000);
    chk("add_ovf.ovf", {31'h0, EX_MEM_Overflow}, 32'h1);
    alu(4'b0110, 32'h8000_0000, 32'h1);
    tick();
    chk("sub_ovf.alu", EX_MEM_ALUResult, 32'h7FFF_FFFF);
    chk("sub_ovf.ovf", {31'h0, EX_MEM_Overflow}, 32'h1);
    alu(4'b0111, 32'hFFFF_FFFF, 32'h1);
    tick();
    chk("slt", EX_MEM_ALUResult, 32'h1);
    chk("slt.ovf", {31'h0, EX_MEM_Overflow}, 32'h0);
    alu(4'b1011, 32'hFFFF_FFFF, 32'h1);
    tick();
    chk("sltu", EX_MEM_ALUResult, 32'h0);
    chk("sltu.zero", {31'h0, EX_MEM_Zero}, 32'h1);
    alu(4'b1010, 32'h0, 32'h8000_0000);
    ID_EX_Shamt = 5'd4;
    tick();
    chk("sra", EX_MEM_ALUResult, 32'hF800_0000);
    alu(4'b1001, 32'h0, 32'h8000_0000);
    tick();
    chk("srl", EX_MEM_ALUResult, 32'h0800_0000);
    alu(4'b1000, 32'h0, 32'h0000_0003);
    tick();
    chk("sll", EX_MEM_ALUResult, 32'h0000_0030);
    alu(4'b1100, 32'h0, 32'h0);
    tick();
    chk("nor", EX_MEM_ALUResult, 32'hFFFF_FFFF);
    alu(4'b1111, 32'h1234, 32'h5678);
    tick();
    chk("op1111", EX_MEM_ALUResult, 32'h0);
    chk("op1111.zero", {31'h0, EX_MEM_Zero}, 32'h1);

    // Store path: B forwarded from prior result, A + Imm for the address.
    alu(4'b0010, 32'hAB, 32'h0);
    tick();
    chk("store.prior", EX_MEM_ALUResult, 32'hAB);
    alu(4'b0010, 32'h100, 32'h55);
    ID_EX_ALUSrc = 1'b1; ID_EX_Imm = 32'd16; forwardB = 2'b10;
    ID_EX_MemWrite = 1'b1; ID_EX_RegWrite = 1'b0;
    tick();
    chk("store.alu", EX_MEM_ALUResult, 32'h110);
    chk("store.wd", EX_MEM_WriteData, 32'hAB);
    chk("store.memwrite", {31'h0, EX_MEM_MemWrite}, 32'h1);
    chk("store.regwrite", {31'h0, EX_MEM_RegWrite}, 32'h0);

    // Stall holds the result for three cycles while inputs change.
    ID_EX_MemWrite = 1'b0; ID_EX_RegWrite = 1'b1; ID_EX_Rd = 5'd6;
    alu(4'b0010, 32'd4, 32'd5);
    tick();
    chk("stall.load", EX_MEM_ALUResult, 32'd9);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu(4'b0110, $urandom, $urandom);
      ID_EX_Rd = 5'(i + 20);
      tick();
      chk("stall.hold.alu", EX_MEM_ALUResult, 32'd9);
      chk("stall.hold.rd", {27'h0, EX_MEM_Rd}, 32'd6);
    end

    // Release: the held result is the one-ahead forward source.
    Stall = 1'b0;
    alu(4'b0010, 32'hDEAD, 32'd1);
    forwardA = 2'b10; ID_EX_Rd = 5'd12;
    tick();
    chk("stall.fwd", EX_MEM_ALUResult, 32'd10);

    // Stall and Flush together: bubble.
    Stall = 1'b1; Flush = 1'b1;
    ID_EX_MemRead = 1'b1; ID_EX_MemToReg = 1'b1;
    alu(4'b0010, 32'd50, 32'd60);
    tick();
    chk_all_zero("flush");

    // Normal load resumes.
    Stall = 1'b0; Flush = 1'b0;
    ID_EX_MemRead = 1'b0; ID_EX_MemToReg = 1'b0;
    alu(4'b0010, 32'd2, 32'd2);
    tick();
    chk("resume", EX_MEM_ALUResult, 32'd4);
    chk("resume.regwrite", {31'h0, EX_MEM_RegWrite}, 32'h1);

    // Destination select.
    ID_EX_Rt = 5'd5; ID_EX_Rd = 5'd9; ID_EX_RegDst = 1'b0;
    tick();
    chk("dest.rt", {27'h0, EX_MEM_Rd}, 32'd5);
    ID_EX_RegDst = 1'b1;
    tick();
    chk("dest.rd", {27'h0, EX_MEM_Rd}, 32'd9);

    // Mid-stream reset beats a pending load and a flush.
    Reset = 1'b1; Flush = 1'b1;
    ID_EX_MemWrite = 1'b1;
    alu(4'b0010, 32'd30, 32'd40);
    tick();
    chk_all_zero("midreset");
    Reset = 1'b0; Flush = 1'b0; ID_EX_MemWrite = 1'b0;
    alu(4'b0010, 32'd1, 32'd1);
    tick();
    chk("after_reset", EX_MEM_ALUResult, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
